quad_decoder: RTL and testbench
===============================

Name: quad_decoder

Overview:
Quadrature front end that feeds the team's up/down counter.
- Synchronises and glitch-filters two asynchronous encoder channels (A, B).
- Decodes each valid Gray-code transition into a one-cycle step pulse plus a direction level.
- `dir` drives the counter's `updown` input; `step` qualifies each count.
- Illegal double-edge transitions are flagged and tallied in a saturating error counter.

Parameters:
- FILTER_LEN, 4, consecutive stable cycles required before a channel change is accepted; legal range 1..255.
- ERR_WIDTH, 8, width of the saturating illegal-transition counter.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- a_in  input  1  encoder channel A; asynchronous to clk.
- b_in  input  1  encoder channel B; asynchronous to clk.
- step  output  1  one-cycle pulse per accepted quadrature edge.
- dir  output  1  1 = up (A leads B), 0 = down; holds last direction.
- err  output  1  one-cycle pulse on an illegal transition (both channels changed in the same cycle).
- err_cnt  output  ERR_WIDTH  saturating count of err pulses.

Behaviour:
Clock and reset:
- One clock, clk; reset rst is synchronous and active-high.
- Reset values: step=0, dir=1, err=0, err_cnt=0, all sync flops 0, filtered channels 0, filter counters 0, FSM=INIT, settle counter 0.

Synchroniser:
- Each channel passes through a 2-flop synchroniser.

Filter (per channel):
- filt_cnt increments while sync != filtered, and clears to 0 when sync == filtered.
- When filt_cnt reaches FILTER_LEN-1 and sync != filtered, the next edge loads filtered <= sync and clears filt_cnt.
- A pulse shorter than FILTER_LEN cycles (post-sync) is discarded.
- Acceptance latency: filtered changes 2+FILTER_LEN cycles after a clean input edge.

Decoder:
- Registers prev = {A_f, B_f} each cycle.
- Up transitions (AB): 00->10, 10->11, 11->01, 01->00.
- Down transitions: 00->01, 01->11, 11->10, 10->00.
- No change: step=0, err=0.
- Both bits change (00<->11, 01<->10): err=1, step=0, dir unchanged.
- Outputs are registered: step/dir/err appear 1 cycle after filtered changes.
- Total latency from a clean pin edge to step is FILTER_LEN+3 cycles.
- dir updates in the same cycle as its step pulse.

FSM:
- INIT: after reset, a settle counter runs for FILTER_LEN+3 cycles.
  - prev tracks filtered every cycle.
  - step and err are forced to 0.
  - Moves to RUN when the settle counter reaches FILTER_LEN+2.
- RUN: normal decode.
- rst asserted in either state returns to INIT with all state cleared.
- INIT suppresses false steps/errors when the encoder rests at a nonzero position at power-up.

err_cnt:
- Increments on each err pulse.
- Saturates at 2^ERR_WIDTH-1; never wraps.

Throughput:
- At most one step per clk.
- Consecutive edges on alternate channels, each stable at least FILTER_LEN cycles, each produce exactly one step.

Decomposition:
- Package quad_pkg holds:
  - State encoding constants ST_INIT and ST_RUN.
  - The 2-bit Gray position constants.
  - An up/down transition lookup function returning {valid, up, illegal}.
- Sub-module quad_filter (2-flop sync + stability filter, parameter FILTER_LEN) is instantiated once per channel.
- Decoder, FSM, and err_cnt live in quad_decoder.

Test Plan:
- Reset with a_in=b_in=1 held, FILTER_LEN=4 -> no step or err during INIT; after 7 cycles FSM=RUN, step=0, err_cnt=0.
- Forward sequence AB 00->10->11->01->00, each held 10 cycles -> exactly 4 step pulses, dir=1 on each, each step 7 cycles after its pin edge.
- Reverse sequence AB 00->01->11->10->00, each held 10 cycles -> 4 steps with dir=0; then 1 more forward edge -> dir=1.
- Glitch: a_in high for 3 cycles then low (FILTER_LEN=4) -> no step, filtered A stays 0. High for 4 cycles -> one step.
- Simultaneous a_in,b_in 00->11 -> err pulse, step=0, dir unchanged, err_cnt=1. With ERR_WIDTH=2, repeat 5 illegal transitions -> err_cnt=3 (saturated).
- rst asserted mid-sequence at AB=11 -> next cycle all outputs at reset values. Release with pins held at 11 -> no step or err, FSM reaches RUN after 7 cycles.

Source files
------------

// File: rtl/quad_pkg.sv
// ---------------------------------------------------------------------------
// quad_pkg
// Shared definitions for the quadrature decoder:
//   - state_t      : decoder FSM states (ST_INIT, ST_RUN)
//   - POS_xx       : 2-bit Gray-code encoder positions, ordered {A, B}
//   - trans_t      : classification of one {A, B} transition
//   - decode_trans : maps (previous, current) position to {valid, up, illegal}
// ---------------------------------------------------------------------------
package quad_pkg;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   localparam logic [1:0] POS_00 = 2'b00;
   localparam logic [1:0] POS_01 = 2'b01;
   localparam logic [1:0] POS_11 = 2'b11;
   localparam logic [1:0] POS_10 = 2'b10;

   typedef struct packed {
      logic valid;    // single-channel edge, counts as a step
      logic up;       // direction of a valid step (1 = A leads B)
      logic illegal;  // both channels moved at once
   } trans_t;

   // No change (and anything unexpected) classifies as all-zero.
   function automatic trans_t decode_trans(input logic [1:0] prev, input logic [1:0] curr);
      trans_t t;
      t = '0;
      case ({prev, curr})
         {POS_00, POS_10}, {POS_10, POS_11},
         {POS_11, POS_01}, {POS_01, POS_00}: begin
            t.valid = 1'b1;
            t.up    = 1'b1;
         end
         {POS_00, POS_01}, {POS_01, POS_11},
         {POS_11, POS_10}, {POS_10, POS_00}: begin
            t.valid = 1'b1;
            t.up    = 1'b0;
         end
         {POS_00, POS_11}, {POS_11, POS_00},
         {POS_01, POS_10}, {POS_10, POS_01}: begin
            t.illegal = 1'b1;
         end
         default: t = '0;
      endcase
      return t;
   endfunction

endpackage

// File: rtl/quad_filter.sv
// ---------------------------------------------------------------------------
// quad_filter
// Two-flop synchroniser followed by a stability filter for one encoder
// channel. A change on the synchronised input is accepted only after it has
// differed from the filtered value for FILTER_LEN consecutive cycles; any
// shorter excursion is discarded.
//
// Ports:
//   clk    : system clock
//   rst    : synchronous active-high reset
//   raw_i  : asynchronous channel input
//   filt_o : synchronised, filtered channel level
// ---------------------------------------------------------------------------
module quad_filter #(
   parameter int FILTER_LEN = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic raw_i,
   output logic filt_o
);

   // FILTER_LEN is at most 255, so FILTER_LEN-1 always fits in 8 bits.
   localparam int CNT_W = 8;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

   logic             sync1_q;
   logic             sync2_q;
   logic             filt_q;
   logic             filt_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // The counter measures how long the synchronised level has disagreed
   // with the filtered level; any agreement restarts the measurement.
   always_comb begin
      filt_d = filt_q;
      cnt_d  = '0;
      if (sync2_q != filt_q) begin
         if (cnt_q == CNT_LAST) begin
            filt_d = sync2_q;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         filt_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= raw_i;
         sync2_q <= sync1_q;
         filt_q  <= filt_d;
         cnt_q   <= cnt_d;
      end
   end

   assign filt_o = filt_q;

endmodule

// File: rtl/quad_decoder.sv
// ---------------------------------------------------------------------------
// quad_decoder
// Quadrature front end for the up/down counter. Each encoder channel is
// synchronised and glitch-filtered, then consecutive filtered positions are
// decoded into a one-cycle step pulse plus a held direction level. Transitions
// where both channels move together are flagged and tallied in a saturating
// counter. After reset an INIT phase lets the filters settle so that an
// encoder resting at a nonzero position does not produce a false step/error.
//
// Ports:
//   clk     : system clock, all logic on posedge
//   rst     : synchronous active-high reset
//   a_in    : encoder channel A (asynchronous)
//   b_in    : encoder channel B (asynchronous)
//   step    : one-cycle pulse per accepted quadrature edge
//   dir     : 1 = up (A leads B), 0 = down; holds last direction
//   err     : one-cycle pulse on an illegal (double-edge) transition
//   err_cnt : saturating count of err pulses
// ---------------------------------------------------------------------------
module quad_decoder
   import quad_pkg::*;
#(
   parameter int FILTER_LEN = 4,
   parameter int ERR_WIDTH  = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 a_in,
   input  logic                 b_in,
   output logic                 step,
   output logic                 dir,
   output logic                 err,
   output logic [ERR_WIDTH-1:0] err_cnt
);

   // Settle counter must reach FILTER_LEN+2 (at most 257): 9 bits.
   localparam int SETTLE_W = 9;
   localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(FILTER_LEN + 2);

   logic [1:0] pin_ab;
   logic [1:0] filt_ab;   // {A_f, B_f}

   assign pin_ab = {a_in, b_in};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_chan
         quad_filter #(
            .FILTER_LEN (FILTER_LEN)
         ) u_filt (
            .clk    (clk),
            .rst    (rst),
            .raw_i  (pin_ab[gi]),
            .filt_o (filt_ab[gi])
         );
      end
   endgenerate

   state_t                state_q;
   state_t                state_d;
   logic [SETTLE_W-1:0]   settle_q;
   logic [SETTLE_W-1:0]   settle_d;
   logic [1:0]            prev_q;
   logic [1:0]            prev_d;
   logic                  step_q;
   logic                  step_d;
   logic                  dir_q;
   logic                  dir_d;
   logic                  err_q;
   logic                  err_d;
   logic [ERR_WIDTH-1:0]  err_cnt_q;
   logic [ERR_WIDTH-1:0]  err_cnt_d;
   trans_t                trans;

   always_comb begin
      state_d   = state_q;
      settle_d  = settle_q;
      prev_d    = filt_ab;     // prev follows the filtered position in every state
      step_d    = 1'b0;
      dir_d     = dir_q;
      err_d     = 1'b0;
      err_cnt_d = err_cnt_q;
      trans     = decode_trans(prev_q, filt_ab);

      case (state_q)
         ST_INIT: begin
            // Covers the synchroniser plus filter latency, so the first
            // settled position is absorbed into prev with no pulse.
            if (settle_q == SETTLE_LAST) begin
               state_d  = ST_RUN;
               settle_d = '0;
            end else begin
               settle_d = settle_q + SETTLE_W'(1);
            end
         end
         ST_RUN: begin
            if (trans.valid) begin
               step_d = 1'b1;
               dir_d  = trans.up;
            end
            if (trans.illegal) begin
               err_d = 1'b1;
               if (err_cnt_q != {ERR_WIDTH{1'b1}}) begin
                  err_cnt_d = err_cnt_q + ERR_WIDTH'(1);
               end
            end
         end
         default: state_d = ST_INIT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_INIT;
         settle_q  <= '0;
         prev_q    <= POS_00;
         step_q    <= 1'b0;
         dir_q     <= 1'b1;
         err_q     <= 1'b0;
         err_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         settle_q  <= settle_d;
         prev_q    <= prev_d;
         step_q    <= step_d;
         dir_q     <= dir_d;
         err_q     <= err_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   assign step    = step_q;
   assign dir     = dir_q;
   assign err     = err_q;
   assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_quad_decoder.sv
// ---------------------------------------------------------------------------
// tb_quad_decoder
// Drives two decoder instances from the same encoder pins: one with default
// parameters and one with ERR_WIDTH=2 to exercise err_cnt saturation.
// A vector table walks forward, reverse and illegal transitions; hand-written
// sequences cover glitch rejection and reset at a nonzero position.
// ---------------------------------------------------------------------------
module tb_quad_decoder;
   import quad_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       a_in;
   logic       b_in;
   logic       step,  dir,  err;
   logic [7:0] err_cnt;
   logic       step2, dir2, err2;
   logic [1:0] err_cnt2;

   always #5 clk = ~clk;

   quad_decoder u_dut (
      .clk     (clk),
      .rst     (rst),
      .a_in    (a_in),
      .b_in    (b_in),
      .step    (step),
      .dir     (dir),
      .err     (err),
      .err_cnt (err_cnt)
   );

   quad_decoder #(
      .FILTER_LEN (4),
      .ERR_WIDTH  (2)
   ) u_dut2 (
      .clk     (clk),
      .rst     (rst),
      .a_in    (a_in),
      .b_in    (b_in),
      .step    (step2),
      .dir     (dir2),
      .err     (err2),
      .err_cnt (err_cnt2)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
      end else begin
         $display("[TB] ok   %s = %0d", name, act);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Results of the most recent watch window.
   int   w_steps, w_errs, w_first, w_steps2, w_errs2;
   logic w_dir_step;

   task automatic watch(input int ncyc);
      w_steps = 0; w_errs = 0; w_first = 0; w_steps2 = 0; w_errs2 = 0;
      w_dir_step = 1'bx;
      for (int k = 1; k <= ncyc; k++) begin
         tick();
         if (step) begin
            w_steps++;
            w_dir_step = dir;
         end
         if (err)   w_errs++;
         if (step2) w_steps2++;
         if (err2)  w_errs2++;
         if ((step || err) && w_first == 0) w_first = k;
      end
   endtask

   typedef struct {
      logic a;
      logic b;
      int   steps;
      int   errs;
      logic dir;
      int   cnt8;
      int   cnt2;
   } vec_t;

   localparam int NVEC = 16;
   localparam int LAT  = 7;   // FILTER_LEN + 3
   vec_t vecs [NVEC];

   task automatic set_vec(input int i, input logic a, input logic b, input int st,
                          input int er, input logic d, input int c8, input int c2);
      vecs[i].a = a; vecs[i].b = b; vecs[i].steps = st; vecs[i].errs = er;
      vecs[i].dir = d; vecs[i].cnt8 = c8; vecs[i].cnt2 = c2;
   endtask

   int   steps, first;
   logic seen;

   initial begin
      //            A     B     stp err dir   cnt8 cnt2
      set_vec( 0, 1'b1, 1'b0, 1, 0, 1'b1, 0, 0);   // 00->10 up
      set_vec( 1, 1'b1, 1'b1, 1, 0, 1'b1, 0, 0);   // 10->11 up
      set_vec( 2, 1'b0, 1'b1, 1, 0, 1'b1, 0, 0);   // 11->01 up
      set_vec( 3, 1'b0, 1'b0, 1, 0, 1'b1, 0, 0);   // 01->00 up
      set_vec( 4, 1'b0, 1'b1, 1, 0, 1'b0, 0, 0);   // 00->01 down
      set_vec( 5, 1'b1, 1'b1, 1, 0, 1'b0, 0, 0);   // 01->11 down
      set_vec( 6, 1'b1, 1'b0, 1, 0, 1'b0, 0, 0);   // 11->10 down
      set_vec( 7, 1'b0, 1'b0, 1, 0, 1'b0, 0, 0);   // 10->00 down
      set_vec( 8, 1'b1, 1'b0, 1, 0, 1'b1, 0, 0);   // 00->10 up again
      set_vec( 9, 1'b0, 1'b0, 1, 0, 1'b0, 0, 0);   // 10->00 down
      set_vec(10, 1'b1, 1'b1, 0, 1, 1'b0, 1, 1);   // 00->11 illegal
      set_vec(11, 1'b0, 1'b0, 0, 1, 1'b0, 2, 2);   // 11->00 illegal
      set_vec(12, 1'b1, 1'b1, 0, 1, 1'b0, 3, 3);
      set_vec(13, 1'b0, 1'b0, 0, 1, 1'b0, 4, 3);   // 2-bit counter saturates
      set_vec(14, 1'b1, 1'b1, 0, 1, 1'b0, 5, 3);
      set_vec(15, 1'b0, 1'b0, 0, 1, 1'b0, 6, 3);

      // ---- Power-up reset at AB=00 ----
      rst = 1'b1; a_in = 1'b0; b_in = 1'b0;
      repeat (3) tick();
      check("rst step",    step,     0);
      check("rst dir",     dir,      1);
      check("rst err",     err,      0);
      check("rst err_cnt", err_cnt,  0);
      check("rst state",   u_dut.state_q, ST_INIT);
      rst = 1'b0;
      watch(10);
      check("init quiet steps", w_steps, 0);
      check("init quiet errs",  w_errs,  0);
      check("init run state",   u_dut.state_q, ST_RUN);

      // ---- Table-driven transitions, each held 10 cycles ----
      for (int i = 0; i < NVEC; i++) begin
         a_in = vecs[i].a;
         b_in = vecs[i].b;
         watch(10);
         check($sformatf("v%0d steps", i),    w_steps,  vecs[i].steps);
         check($sformatf("v%0d errs", i),     w_errs,   vecs[i].errs);
         check($sformatf("v%0d latency", i),  w_first,  LAT);
         check($sformatf("v%0d dir", i),      dir,      vecs[i].dir);
         check($sformatf("v%0d err_cnt", i),  err_cnt,  vecs[i].cnt8);
         check($sformatf("v%0d err_cnt2", i), err_cnt2, vecs[i].cnt2);
         check($sformatf("v%0d steps2", i),   w_steps2 + w_errs2, vecs[i].steps + vecs[i].errs);
         check($sformatf("v%0d dir2", i),     dir2,     vecs[i].dir);
         if (vecs[i].steps > 0)
            check($sformatf("v%0d dir@step", i), w_dir_step, vecs[i].dir);
      end

      // ---- Glitch: A high for 3 samples is discarded ----
      a_in = 1'b1;
      repeat (3) tick();
      a_in = 1'b0;
      seen = 1'b0; steps = 0;
      for (int k = 0; k < 15; k++) begin
         tick();
         if (u_dut.filt_ab[1]) seen = 1'b1;
         if (step) steps++;
      end
      check("glitch3 filtA", seen,  0);
      check("glitch3 steps", steps, 0);

      // ---- A high for 4 samples is accepted: rise step, later fall step ----
      a_in = 1'b1;
      repeat (4) tick();
      a_in = 1'b0;
      seen = 1'b0; steps = 0; first = 0;
      for (int k = 1; k <= 5; k++) begin
         tick();
         if (u_dut.filt_ab[1]) seen = 1'b1;
         if (step) begin
            steps++;
            if (first == 0) first = k;
         end
      end
      check("glitch4 filtA",  seen,  1);
      check("glitch4 steps",  steps, 1);
      check("glitch4 offset", first, 3);   // 7 cycles after the pin edge
      check("glitch4 dir",    dir,   1);
      watch(10);
      check("glitch4 fall steps", w_steps, 1);
      check("glitch4 fall dir",   dir,     0);

      // ---- Reset mid-sequence at AB=11, then restart at rest position 11 ----
      a_in = 1'b0; b_in = 1'b1;
      watch(10);
      a_in = 1'b1; b_in = 1'b1;
      watch(10);
      check("pre-rst dir",     dir,     0);
      check("pre-rst err_cnt", err_cnt, 6);
      rst = 1'b1;
      tick();
      check("midrst step",     step,     0);
      check("midrst dir",      dir,      1);
      check("midrst err",      err,      0);
      check("midrst err_cnt",  err_cnt,  0);
      check("midrst err_cnt2", err_cnt2, 0);
      check("midrst state",    u_dut.state_q, ST_INIT);
      tick();
      rst = 1'b0;
      steps = 0; first = 0;
      for (int k = 1; k <= 12; k++) begin
         tick();
         if (step || err) steps++;
         if (k == 6) check("settle state@6", u_dut.state_q, ST_INIT);
         if (k == 7) check("settle state@7", u_dut.state_q, ST_RUN);
      end
      check("settle quiet", steps, 0);
      a_in = 1'b0;   // 11->01 up
      watch(10);
      check("post-rst steps",   w_steps, 1);
      check("post-rst latency", w_first, LAT);
      check("post-rst dir",     dir,     1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
